// File: rtl/mod_exp_pkg.sv
// Shared constants for the modular-exponentiation sequencer and the
// Montgomery product engine (mon_prod): op codes, FSM states, scan phases.
package mod_exp_pkg;

  localparam int CNT_W_DEFAULT = 11;

  // Op codes understood by mon_prod
  localparam logic [1:0] OPXX = 2'd0;  // square
  localparam logic [1:0] OPXM = 2'd1;  // multiply by M_bar
  localparam logic [1:0] OPX1 = 2'd2;  // multiply by 1 (leave Montgomery domain)

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SQR,
    PH_MUL,
    PH_FINAL
  } phase_t;

  function automatic logic [1:0] phase_op(input phase_t ph);
    case (ph)
      PH_SQR:   phase_op = OPXX;
      PH_MUL:   phase_op = OPXM;
      PH_FINAL: phase_op = OPX1;
      default:  phase_op = OPXX;
    endcase
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_exp_scanner.sv
// exp_scanner: holds the latched exponent and walks a bit index from
// exp_len-1 down to 0. exp_len is clamped to EXP_BITS at load time.
// Pure datapath: no reset, every job starts with a load.
module exp_scanner
  import mod_exp_pkg::*;
#(
  parameter int EXP_BITS = 1024,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                load,
  input  logic [EXP_BITS-1:0] exp_in,
  input  logic [CNT_W-1:0]    len,
  input  logic                dec,
  output logic                len_zero,
  output logic                bit_cur,
  output logic                idx_zero
);

  localparam int IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

  logic [EXP_BITS-1:0] exp_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    len_c;

  // Clamp the requested length and flag the empty-exponent case
  always_comb begin
    len_c    = (len > CNT_W'(EXP_BITS)) ? CNT_W'(EXP_BITS) : len;
    len_zero = (len == '0);
  end

  // Latch exponent on job accept, then count the index down on request
  always_ff @(posedge clk) begin
    if (load) begin
      exp_q <= exp_in;
      idx_q <= IDX_W'(len_c - 1'b1);
    end else if (dec) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  // Current exponent bit and last-bit flag
  always_comb begin
    bit_cur  = exp_q[idx_q];
    idx_zero = (idx_q == '0);
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer driving mon_prod.
// Each exponent bit costs one OPXX, plus one OPXM when the bit is set; the
// job ends with one OPX1 conversion, then a one-cycle done pulse.
// Optional feature: define MOD_EXP_CYCLE_CNT_EN to build the job cycle
// counter; otherwise cycle_cnt is tied to zero.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int EXP_BITS     = 1024,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int MP_COUNT     = 1024,
  parameter int FLUSH_CYCLES = 2200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [EXP_BITS-1:0] exp,
  input  logic [CNT_W-1:0]    exp_len,
  output logic                busy,
  output logic                done,
  output logic [31:0]         cycle_cnt,
  output logic                mp_start,
  output logic [1:0]          mp_op_code,
  output logic [9:0]          mp_count,
  input  logic                mp_stop
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [FLUSH_W-1:0] flush_q;
  logic               wait_arm_q;
  logic               accept;
  logic               scan_dec;
  logic               len_zero;
  logic               bit_cur;
  logic               idx_zero;

  assign accept = (state_q == ST_IDLE) && start;

  exp_scanner #(
    .EXP_BITS (EXP_BITS),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk      (clk),
    .load     (accept),
    .exp_in   (exp),
    .len      (exp_len),
    .dec      (scan_dec),
    .len_zero (len_zero),
    .bit_cur  (bit_cur),
    .idx_zero (idx_zero)
  );

  // State and phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FLUSH;
      phase_q <= PH_SQR;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state and phase decisions
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    scan_dec = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (mp_stop || (flush_q == FLUSH_LAST)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          phase_d = len_zero ? PH_FINAL : PH_SQR;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // The first WAIT cycle still sees the previous op's stop level
        if (wait_arm_q && mp_stop) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = ST_ISSUE;
        if ((phase_q == PH_SQR) && bit_cur) begin
          phase_d = PH_MUL;
        end else if (phase_q == PH_FINAL) begin
          state_d = ST_DONE;
        end else if (idx_zero) begin
          phase_d = PH_FINAL;
        end else begin
          scan_dec = 1'b1;
          phase_d  = PH_SQR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_FLUSH;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    mp_start   = (state_q == ST_ISSUE);
    mp_op_code = phase_op(phase_q);
    // A full 1024-iteration count wraps to 0 in the 10-bit field
    mp_count   = 10'(MP_COUNT);
  end

  // Post-reset drain timer; mon_prod has no reset of its own
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q <= '0;
    end else if ((state_q == ST_FLUSH) && (flush_q != FLUSH_LAST)) begin
      flush_q <= flush_q + 1'b1;
    end
  end

  // Arms the stop check from the second WAIT cycle onward
  always_ff @(posedge clk) begin
    if (reset) wait_arm_q <= 1'b0;
    else       wait_arm_q <= (state_q == ST_WAIT);
  end

`ifdef MOD_EXP_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  logic        in_job;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign in_job = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                  (state_q == ST_NEXT)  || (state_q == ST_DONE);

  // Job cycle counter: ISSUE through DONE inclusive, held while idle
  always_ff @(posedge clk) begin
    if (reset)       cyc_q <= '0;
    else if (accept) cyc_q <= '0;
    else if (in_job) cyc_q <= sat_inc(cyc_q);
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Testbench for mod_exp_ctrl with a behavioural mon_prod model
// (stop drops one cycle after start and rises N cycles after start).
module tb_mod_exp_ctrl;

  localparam int EXP_BITS     = 1024;
  localparam int CNT_W        = 11;
  localparam int MP_COUNT     = 1024;
  localparam int FLUSH_CYCLES = 2200;
  localparam int N            = 10;
  localparam int OP_CYC       = 1 + 1 + N + 1;  // ISSUE + stale WAIT + N + NEXT

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [EXP_BITS-1:0] exp;
  logic [CNT_W-1:0]    exp_len;
  logic                busy;
  logic                done;
  logic [31:0]         cycle_cnt;
  logic                mp_start;
  logic [1:0]          mp_op_code;
  logic [9:0]          mp_count;
  logic                mp_stop;

  always #5 clk = ~clk;

  mod_exp_ctrl #(
    .EXP_BITS     (EXP_BITS),
    .CNT_W        (CNT_W),
    .MP_COUNT     (MP_COUNT),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .exp        (exp),
    .exp_len    (exp_len),
    .busy       (busy),
    .done       (done),
    .cycle_cnt  (cycle_cnt),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_count   (mp_count),
    .mp_stop    (mp_stop)
  );

  // mon_prod model plus op/done recorders
  logic       stop_q   = 1'b1;
  logic       clr_pend = 1'b0;
  logic       hold_low = 1'b0;
  int         mcnt     = 0;
  logic [1:0] cur_code = 2'd0;
  int         done_cnt = 0;
  int         unstable = 0;
  logic [1:0] ops[$];

  assign mp_stop = stop_q & ~hold_low;

  always @(posedge clk) begin
    if (mp_start) begin
      mcnt     <= N;
      clr_pend <= 1'b1;
      cur_code <= mp_op_code;
      ops.push_back(mp_op_code);
    end else begin
      if (clr_pend) begin
        stop_q   <= 1'b0;
        clr_pend <= 1'b0;
      end
      if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) stop_q <= 1'b1;
      end
    end
    if (done) done_cnt <= done_cnt + 1;
    if ((mcnt > 0) && !reset && (mp_op_code != cur_code)) unstable <= unstable + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic launch(input logic [EXP_BITS-1:0] e, input int len);
    @(negedge clk);
    ops.delete();
    exp     = e;
    exp_len = CNT_W'(len);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] e;
    int          len;
    int          nops;
    logic [63:0] seq;  // nibble i = op code of op i
  } vec_t;

  vec_t        tbl[6];
  logic [63:0] seq;
  bit          seen;
  int          d0;
  int          exp_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{e: 16'h000B, len: 4, nops: 8, seq: 64'h2101_0010};
    tbl[1] = '{e: 16'h0000, len: 0, nops: 1, seq: 64'h2};
    tbl[2] = '{e: 16'h0007, len: 3, nops: 7, seq: 64'h210_1010};
    tbl[3] = '{e: 16'h0001, len: 1, nops: 3, seq: 64'h210};
    tbl[4] = '{e: 16'h0004, len: 3, nops: 5, seq: 64'h2_0010};
    tbl[5] = '{e: 16'h0008, len: 3, nops: 4, seq: 64'h2000};

    reset   = 1'b1;
    start   = 1'b0;
    exp     = '0;
    exp_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_mp_start", mp_start, 0);
    check("rst_op_code", mp_op_code, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("mp_count", mp_count, 10'd0);

    // Flush ends one cycle after reset when mon_prod already reports stop
    reset = 1'b0;
    @(negedge clk);
    check("flush_fast_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_mp_start", mp_start, 0);

    // Flush times out after exactly FLUSH_CYCLES when stop never rises
    hold_low = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= FLUSH_CYCLES; i++) begin
      @(negedge clk);
      if (i == FLUSH_CYCLES - 1) check("flush_timeout_still_busy", busy, 1);
    end
    check("flush_timeout_idle", busy, 0);
    hold_low = 1'b0;

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      launch(EXP_BITS'(tbl[v].e), tbl[v].len);
      wait_done(400, seen);
      check("done_seen", seen, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      check("op_count", ops.size(), tbl[v].nops);
      seq = tbl[v].seq;
      for (int i = 0; i < ops.size() && i < 16; i++)
        check("op_code", ops[i], seq[4*i +: 2]);
      check("done_pulses", done_cnt - d0, 1);
`ifdef MOD_EXP_CYCLE_CNT_EN
      exp_cyc = tbl[v].nops * OP_CYC + 1;
`else
      exp_cyc = 0;
`endif
      check("cycle_cnt", cycle_cnt, exp_cyc);
    end

    // Start pulses during the job and on the done cycle are ignored
    d0 = done_cnt;
    launch(EXP_BITS'(7), 3);
    exp     = '1;
    exp_len = CNT_W'(9);
    seen    = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        start = (i % 4 == 1);
        @(negedge clk);
      end
    end
    check("ign_done_seen", seen, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy_after_done", busy, 0);
    repeat (5) @(negedge clk);
    check("ign_still_idle", busy, 0);
    check("ign_op_count", ops.size(), 7);
    if (ops.size() == 7) begin
      check("ign_op1", ops[1], 1);
      check("ign_op6", ops[6], 2);
    end
    check("ign_done_pulses", done_cnt - d0, 1);

    // Reset while op 3 is in flight abandons the job
    d0 = done_cnt;
    launch(EXP_BITS'(11), 4);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (ops.size() >= 3) seen = 1'b1;
      else @(negedge clk);
    end
    check("midrst_op3_issued", seen, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midrst_flush_busy", busy, 1);
    check("midrst_cycle_cnt", cycle_cnt, 0);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (!busy) seen = 1'b1;
      else @(negedge clk);
    end
    check("midrst_flush_exit", seen, 1);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_extra_op", ops.size(), 3);

    // Job after the abandoned one
    d0 = done_cnt;
    launch(EXP_BITS'(1), 1);
    wait_done(400, seen);
    check("post_rst_done_seen", seen, 1);
    @(negedge clk);
    check("post_rst_op_count", ops.size(), 3);
    if (ops.size() == 3) begin
      check("post_rst_op0", ops[0], 0);
      check("post_rst_op1", ops[1], 1);
      check("post_rst_op2", ops[2], 2);
    end
    check("post_rst_done_pulses", done_cnt - d0, 1);
`ifdef MOD_EXP_CYCLE_CNT_EN
    exp_cyc = 40;
`else
    exp_cyc = 0;
`endif
    check("post_rst_cycle_cnt", cycle_cnt, exp_cyc);

    // exp_len beyond EXP_BITS clamps: 1024 squares, one multiply, one final
    launch(EXP_BITS'(1), 1500);
    wait_done(1026 * OP_CYC + 50, seen);
    check("clamp_done_seen", seen, 1);
    @(negedge clk);
    check("clamp_op_count", ops.size(), 1026);
    if (ops.size() == 1026) begin
      check("clamp_op1023", ops[1023], 0);
      check("clamp_op1024", ops[1024], 1);
      check("clamp_op1025", ops[1025], 2);
    end

    check("op_code_stable", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
